// File: rtl/mmio_uart_tx.sv
//------------------------------------------------------------------------------
// Module   : mmio_uart_tx
// Brief    : Store-bus snooping UART transmitter (8N1) with byte FIFO and
//            a readable status word.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = 32'hFFFF_FF00,
  parameter logic [31:0] STATUS_ADDR  = 32'hFFFF_FF04
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] C_BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_DEPTH     = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [BW-1:0]   r_baud;
  logic [BW-1:0]   w_baud_nxt;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_idx_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic            r_tx;
  logic            w_tx_nxt;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;

  logic            w_tx_sel;
  logic            w_st_sel;
  logic            w_push_req;
  logic            w_clr;
  logic            w_empty;
  logic            w_full;
  logic            w_baud_last;
  logic            w_pop;
  logic            w_push_ok;
  logic [31:0]     w_status;
  logic            w_unused;

  assign w_tx_sel    = (dataadr == TX_ADDR);
  assign w_st_sel    = (dataadr == STATUS_ADDR);
  assign w_push_req  = memwrite & w_tx_sel;
  assign w_clr       = memwrite & w_st_sel;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == C_DEPTH);
  assign w_baud_last = (r_baud == C_BAUD_LAST);
  // A pop frees a slot on the same edge, so a store into a full FIFO still lands.
  assign w_push_ok   = w_push_req & (~w_full | w_pop);
  assign w_unused    = ^writedata[31:8];

  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_baud_nxt  = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_last) begin
          w_baud_nxt    = '0;
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = S_DATA;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_baud_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      S_STOP: begin
        if (w_baud_last) begin
          w_baud_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rd_ptr];
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: begin
        w_baud_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
    endcase

    // tx is registered from the next-state view so the line is glitch-free.
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[w_bit_idx_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= writedata[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A drop and a clear on the same edge resolve to set.
      if (w_push_req & w_full & ~w_pop) begin
        r_overflow <= 1'b1;
      end else if (w_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    w_status           = '0;
    w_status[0]        = busy;
    w_status[1]        = w_empty;
    w_status[2]        = w_full;
    w_status[3]        = r_overflow;
    w_status[8 +: CW]  = r_count;
  end

  assign busy  = (r_state != S_IDLE);
  assign tx    = r_tx;
  assign hit   = w_tx_sel | w_st_sel;
  assign rdata = w_st_sel ? w_status : 32'h0;

endmodule

`default_nettype wire

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the processor's data-memory store bus, downstream of the MIPS core alongside dmem. It snoops memwrite/dataadr/writedata. Stores to the TX data address push the low byte into a small FIFO; the block serialises each byte as an 8N1 frame on a single tx line. A status word can be read back at a second address.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; must be >= 2.
FIFO_DEPTH, 8, FIFO entries; must be a power of 2, range 2..128.
TX_ADDR, 32'hFFFF_FF00, byte address of the TX data register (write-only).
STATUS_ADDR, 32'hFFFF_FF04, byte address of the status register (read; a write clears overflow).

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
memwrite  in  1  store strobe from the core
dataadr  in  32  store/load byte address from the core
writedata  in  32  store data; only [7:0] used
hit  out  1  combinational; 1 when dataadr == TX_ADDR or dataadr == STATUS_ADDR (top uses it to mux rdata over dmem)
rdata  out  32  combinational; status word when dataadr == STATUS_ADDR, else 0
tx  out  1  serial output, idle high
busy  out  1  1 whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. While reset is asserted: tx=1, state=IDLE, FIFO empty (rd/wr pointers and count = 0), overflow=0, busy=0, all bit/baud counters = 0. Reset mid-frame aborts the frame immediately, with no completion of the stop bit.
- Push: on an edge where memwrite && dataadr==TX_ADDR:
  - If the FIFO is not full, writedata[7:0] is written at wr_ptr, wr_ptr increments modulo FIFO_DEPTH, count+1.
  - If the FIFO is full and no pop occurs that edge, the byte is dropped and overflow is set. overflow is sticky.
  - If full and a pop occurs on the same edge, the push is accepted and count is unchanged.
- Overflow clear: an edge with memwrite && dataadr==STATUS_ADDR clears overflow. If a drop and a clear fall on the same edge, set wins; this cannot happen from one address, so it is documented only.
- Other addresses: stores to any other address have no effect.
- Status word, bit by bit:
  - [0] busy
  - [1] empty (count==0)
  - [2] full (count==FIFO_DEPTH)
  - [3] overflow
  - [15:8] count
  - all other bits 0
- FSM states: IDLE, START, DATA, STOP. baud counts 0..CLKS_PER_BIT-1; bit_idx counts 0..7.
  - IDLE: tx=1. If the FIFO is non-empty at an edge: pop the head into shift_reg, baud=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift_reg[bit_idx], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the final STOP cycle's edge: if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- tx is a registered output (no glitches); it reflects the current state and bit.
- Timing:
  - Latency: a store captured at edge k makes the FIFO non-empty after k. With the FSM in IDLE, the pop happens at edge k+1 and tx falls after edge k+1.
  - A frame is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have zero idle cycles between them.
- Counter widths: count is $clog2(FIFO_DEPTH)+1 bits. Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

Test Plan:
- Single byte (CLKS_PER_BIT=4): reset, then store 32'h1234_56A5 to TX_ADDR -> tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 cycles total), tx falls 1 cycle after the store edge; busy=1 for exactly 40 cycles; the upper writedata bits are ignored.
- Address decode: store 0x55 to 32'h0000_0040, then load STATUS_ADDR -> tx stays 1, hit=0 for the first address, rdata=32'h0000_0002 (empty only).
- Overflow (depth 8): 10 consecutive-cycle stores of bytes 0..9 -> byte 0 is popped after 1 cycle; bytes 1..8 are queued; byte 9 is dropped, overflow=1, status count=8 right after; exactly 9 frames (bytes 0..8) follow back-to-back; afterwards a store to STATUS_ADDR -> overflow=0, status=32'h0000_0002.
- Push at full with simultaneous pop: fill the FIFO to 8 while frame 0 is in STOP, and time a store on its final STOP edge -> the store is accepted, count stays 8, overflow stays 0.
- Reset mid-frame: assert reset during DATA bit 3 -> tx=1 and busy=0 asynchronously (before the next edge); after release, status=32'h0000_0002 and no residual frame is sent.
- Status count: store 3 bytes with the FSM busy -> rdata[15:8] tracks 1,2,3, then decrements by 1 at each frame start.
